// File: rtl/dice_roll_ctrl.sv
// Roll animation controller: samples the 1..6 dice stream during a timed
// roll, freezes the final face and offers it downstream via valid/ready.
// Optional per-face roll histogram is enabled by defining DICE_HIST_EN.
module dice_roll_ctrl #(
    parameter int ANIM_CYCLES = 16,
    parameter int TICK_DIV    = 4,
    parameter int HIST_W      = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       roll_req,
    input  logic [2:0] numero_in,
    output logic [2:0] dado_out,
    output logic       dado_valid,
    input  logic       dado_ready,
    output logic       rolling,
    output logic       err_range
`ifdef DICE_HIST_EN
    ,
    output logic [6*HIST_W-1:0] hist_flat
`endif
);

    localparam int AW = $clog2(ANIM_CYCLES + 1);
    localparam int DW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [AW-1:0] ANIM_LD = AW'(ANIM_CYCLES);
    localparam logic [DW-1:0] DIV_TOP = DW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ROLL = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic            r_req_q;
    logic [AW-1:0]   r_anim_cnt;
    logic [DW-1:0]   r_div_cnt;
    logic [2:0]      r_dado;
    logic            r_err;

    logic            w_start;
    logic            w_tick;
    logic            w_final;
    logic            w_bad;
    logic [2:0]      w_sample;

    // Rising edge of the (level) roll button
    assign w_start  = roll_req & ~r_req_q;
    assign w_tick   = (r_state == S_ROLL) && (r_div_cnt == DIV_TOP);
    assign w_final  = w_tick && (r_anim_cnt == AW'(1));
    assign w_bad    = (numero_in == 3'd0) || (numero_in == 3'd7);
    assign w_sample = w_bad ? 3'd1 : numero_in;

    assign dado_out  = r_dado;
    assign err_range = r_err;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic: start only honoured in IDLE, ready only in HOLD
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_start) w_next = S_ROLL;
            S_ROLL: if (w_final) w_next = S_HOLD;
            S_HOLD: if (dado_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Status outputs decoded from the current state
    always_comb begin
        rolling    = 1'b0;
        dado_valid = 1'b0;
        case (r_state)
            S_ROLL:  rolling    = 1'b1;
            S_HOLD:  dado_valid = 1'b1;
            default: ;
        endcase
    end

    // Edge detector, animation counters, displayed face and error pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_req_q    <= 1'b0;
            r_anim_cnt <= '0;
            r_div_cnt  <= '0;
            r_dado     <= 3'd0;
            r_err      <= 1'b0;
        end else begin
            r_req_q <= roll_req;
            r_err   <= w_tick & w_bad;
            if ((r_state == S_IDLE) && w_start) begin
                r_anim_cnt <= ANIM_LD;
                r_div_cnt  <= '0;
            end else if (r_state == S_ROLL) begin
                if (w_tick) begin
                    r_div_cnt  <= '0;
                    r_anim_cnt <= r_anim_cnt - AW'(1);
                    r_dado     <= w_sample;
                end else begin
                    r_div_cnt <= r_div_cnt + DW'(1);
                end
            end
        end
    end

`ifdef DICE_HIST_EN
    logic [HIST_W-1:0] r_hist [6];

    // Saturating per-face count of final faces
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int f = 0; f < 6; f++) begin
                r_hist[f] <= '0;
            end
        end else begin
            for (int f = 0; f < 6; f++) begin
                if (w_final && (w_sample == 3'(f + 1)) &&
                    (r_hist[f] != {HIST_W{1'b1}})) begin
                    r_hist[f] <= r_hist[f] + HIST_W'(1);
                end
            end
        end
    end

    for (genvar g = 0; g < 6; g++) begin : g_hist
        assign hist_flat[(g+1)*HIST_W-1 -: HIST_W] = r_hist[g];
    end
`endif

endmodule

// File: tb/tb_dice_roll_ctrl.sv
// Scoreboard bench for dice_roll_ctrl: random dice streams, a
// per-roll reference of sampled faces, and a negedge monitor.
module tb_dice_roll_ctrl;

    localparam int ANIM = 3;
    localparam int TDIV = 2;
    localparam int N    = ANIM * TDIV;
`ifdef DICE_HIST_EN
    localparam int HW = 2;
`else
    localparam int HW = 8;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       roll_req = 1'b0;
    logic       dado_ready = 1'b0;
    logic [2:0] numero_in = 3'd0;
    logic [2:0] dado_out;
    logic       dado_valid;
    logic       rolling;
    logic       err_range;
`ifdef DICE_HIST_EN
    logic [6*HW-1:0] hist_flat;
`endif

    dice_roll_ctrl #(
        .ANIM_CYCLES(ANIM),
        .TICK_DIV   (TDIV),
        .HIST_W     (HW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .roll_req  (roll_req),
        .numero_in (numero_in),
        .dado_out  (dado_out),
        .dado_valid(dado_valid),
        .dado_ready(dado_ready),
        .rolling   (rolling),
        .err_range (err_range)
`ifdef DICE_HIST_EN
        ,
        .hist_flat (hist_flat)
`endif
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int q_face[$];
    int q_anim[$];
    int exp_err  = 0;
    int err_seen = 0;
    int hist_cnt[6];
    int seq[N];

    int  roll_cyc   = 0;
    int  cur_face   = 0;
    bit  last_valid = 1'b0;
    bit  last_ready = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int face_of(input int v);
        return (v == 0 || v == 7) ? 1 : v;
    endfunction

    function automatic int rand_val();
        int v;
        v = int'($urandom_range(0, 15));
        if (v < 12) return 1 + (v % 6);
        return (v < 14) ? 0 : 7;
    endfunction

    task automatic fill_random();
        for (int i = 0; i < N; i++) seq[i] = rand_val();
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_dado_out"}, int'(dado_out), 0);
        check({tag, "_dado_valid"}, int'(dado_valid), 0);
        check({tag, "_rolling"}, int'(rolling), 0);
        check({tag, "_err_range"}, int'(err_range), 0);
`ifdef DICE_HIST_EN
        check({tag, "_hist"}, int'(hist_flat), 0);
`endif
    endtask

    task automatic check_hist();
`ifdef DICE_HIST_EN
        int mx;
        mx = (1 << HW) - 1;
        for (int f = 0; f < 6; f++) begin
            check($sformatf("hist_face%0d", f + 1),
                  int'(hist_flat[(f+1)*HW-1 -: HW]),
                  (hist_cnt[f] > mx) ? mx : hist_cnt[f]);
        end
`endif
    endtask

    // mode 0: plain pulse; 1: extra pulses in ROLL and HOLD; 2: held high
    task automatic do_roll(input int mode, input int rdy_dly);
        int v;
        roll_req = 1'b0;
        @(posedge clk); #2;
        roll_req = 1'b1;
        for (int k = 1; k <= ANIM; k++) begin
            v = face_of(seq[k*TDIV-1]);
            if (seq[k*TDIV-1] == 0 || seq[k*TDIV-1] == 7) exp_err++;
            if (k < ANIM) q_anim.push_back(v);
            else begin
                q_face.push_back(v);
                hist_cnt[v-1]++;
            end
        end
        @(posedge clk); #2;
        if (mode != 2) roll_req = 1'b0;
        for (int i = 0; i < N; i++) begin
            numero_in = 3'(seq[i]);
            if (mode == 1 && i == 1) roll_req = 1'b1;
            if (mode == 1 && i == 3) roll_req = 1'b0;
            dado_ready = 1'($urandom_range(0, 1));
            @(posedge clk); #2;
        end
        dado_ready = 1'b0;
        for (int d = 0; d < rdy_dly; d++) begin
            numero_in = 3'($urandom_range(0, 7));
            if (mode == 1) roll_req = (d == 0);
            @(posedge clk); #2;
        end
        if (mode == 1) roll_req = 1'b0;
        dado_ready = 1'b1;
        @(posedge clk); #2;
        dado_ready = 1'b0;
        if (mode == 2) begin
            repeat (4) begin
                @(posedge clk); #2;
            end
            roll_req = 1'b0;
        end
    endtask

    // Monitor: compares animation samples, final face and handshake
    always @(negedge clk) begin
        if (rst) begin
            roll_cyc   = 0;
            last_valid = 1'b0;
            last_ready = 1'b0;
        end else begin
            if (rolling) begin
                roll_cyc++;
                if (roll_cyc > 1 && ((roll_cyc - 1) % TDIV) == 0) begin
                    if (q_anim.size() == 0) check("anim_unexpected", 1, 0);
                    else check("anim_sample", int'(dado_out), q_anim.pop_front());
                end
            end
            if (rolling && dado_valid) check("rolling_and_valid", 1, 0);
            if (dado_valid && !last_valid) begin
                check("roll_cycles", roll_cyc, N);
                roll_cyc = 0;
                if (q_face.size() == 0) check("face_unexpected", 1, 0);
                else begin
                    cur_face = q_face.pop_front();
                    check("final_face", int'(dado_out), cur_face);
                end
            end else if (dado_valid) begin
                check("hold_stable", int'(dado_out), cur_face);
            end
            if (last_valid) begin
                check("valid_handshake", int'(dado_valid), last_ready ? 0 : 1);
                if (!dado_valid) check("face_retained", int'(dado_out), cur_face);
            end
            if (err_range) err_seen++;
            last_valid = dado_valid;
            last_ready = dado_ready;
        end
    end

    initial begin
        for (int f = 0; f < 6; f++) hist_cnt[f] = 0;
        #2 rst = 1'b1;
        #1 check_outputs_zero("reset");
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;

        for (int r = 0; r < 4; r++) begin
            fill_random();
            seq[N-1] = 3;
            do_roll(0, int'($urandom_range(0, 3)));
        end
        repeat (2) @(posedge clk);
        #2 check_hist();

        seq = '{2, 3, 4, 5, 6, 1};
        do_roll(0, 10);

        fill_random();
        seq[N-1] = 7;
        do_roll(1, 3);

        fill_random();
        do_roll(2, 2);

        for (int r = 0; r < 30; r++) begin
            int m;
            m = int'($urandom_range(0, 2));
            fill_random();
            do_roll(m, (m == 0) ? int'($urandom_range(0, 5))
                                : int'($urandom_range(2, 5)));
        end

        repeat (4) @(posedge clk);
        #2;
        check("face_queue_drained", q_face.size(), 0);
        check("anim_queue_drained", q_anim.size(), 0);
        check("err_pulse_count", err_seen, exp_err);
        check_hist();

        fill_random();
        roll_req = 1'b0;
        @(posedge clk); #2;
        roll_req = 1'b1;
        @(posedge clk); #2;
        roll_req = 1'b0;
        numero_in = 3'(seq[0]);
        @(posedge clk); #3;
        check("rolling_before_rst", int'(rolling), 1);
        rst = 1'b1;
        #1 check_outputs_zero("mid_roll_rst");
        for (int f = 0; f < 6; f++) hist_cnt[f] = 0;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        repeat (3) @(posedge clk);
        #2 check("idle_after_rst", int'(rolling), 0);

        fill_random();
        do_roll(0, 1);
        repeat (4) @(posedge clk);
        #2;
        check("face_queue_final", q_face.size(), 0);
        check("anim_queue_final", q_anim.size(), 0);
        check("err_pulse_final", err_seen, exp_err);
        check_hist();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
